mem_stage_hs: RTL and testbench

MEM_STAGE_HS -- requirements
Module: mem_stage_hs

---
 rtl/mem_stage_hs_pkg.sv | 16 +
 rtl/mem_wb_mux.sv | 25 ++
 rtl/mem_stage_hs.sv | 168 ++++++++++++++++
 tb/tb_mem_stage_hs.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_hs_pkg.sv
// Shared encodings for the MEM stage: write-back source select and FSM state.
package mem_stage_hs_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'd0,
        WB_MEM  = 2'd1,
        WB_PC1  = 2'd2,
        WB_ZERO = 2'd3
    } wbSrc_e;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } memState_e;

endpackage

// File: rtl/mem_wb_mux.sv
// Write-back value selection for the MEM stage.
module mem_wb_mux
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic [1:0]       wbSrc,
    input  logic [WIDTH-1:0] aluOut,
    input  logic [WIDTH-1:0] memData,
    input  logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] selData_c
);

    always_comb begin
        selData_c = '0;
        case (wbSrc_e'(wbSrc))
            WB_ALU:  selData_c = aluOut;
            WB_MEM:  selData_c = memData;
            WB_PC1:  selData_c = pc + WIDTH'(1);
            WB_ZERO: selData_c = '0;
            default: selData_c = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// Pipeline MEM stage with a request/ack memory handshake and upstream stall.
// Optional forwarding outputs are built when MEM_STAGE_FWD_EN is defined.
module mem_stage_hs
    import mem_stage_hs_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned RADDR_W = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_pc,
    input  logic [WIDTH-1:0]   in_alu_out,
    input  logic [WIDTH-1:0]   in_store_data,
    input  logic [RADDR_W-1:0] in_rd,
    input  logic               in_mem_read,
    input  logic               in_mem_write,
    input  logic [1:0]         in_wb_src,
    input  logic               in_reg_write,
    input  logic               in_flush,
    output logic               stall_out,
    output logic               mem_read,
    output logic               mem_write,
    output logic [WIDTH-1:0]   mem_addr,
    output logic [WIDTH-1:0]   mem_wdata,
    input  logic [WIDTH-1:0]   mem_rdata,
    input  logic               mem_ack,
`ifdef MEM_STAGE_FWD_EN
    output logic               fwd_valid,
    output logic [RADDR_W-1:0] fwd_rd,
    output logic [WIDTH-1:0]   fwd_data,
`endif
    output logic               wb_valid,
    output logic [WIDTH-1:0]   wb_pc,
    output logic [RADDR_W-1:0] wb_rd,
    output logic               wb_reg_write,
    output logic [WIDTH-1:0]   wb_data
);

    memState_e          state;
    memState_e          nextState;

    logic               exValid;
    logic [WIDTH-1:0]   exPc;
    logic [WIDTH-1:0]   exAlu;
    logic [WIDTH-1:0]   exStore;
    logic [RADDR_W-1:0] exRd;
    logic               exMemRd;
    logic               exMemWr;
    logic [1:0]         exWbSrc;
    logic               exRegWr;

    logic               acceptMem;
    logic               stallC;
    logic               wbLoadC;
    logic [WIDTH-1:0]   muxDataC;

    assign acceptMem = in_valid && !in_flush && (in_mem_read || in_mem_write);
    assign stall_out = stallC;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state, memory request and MEM/WB load enable
    always_comb begin
        nextState = state;
        stallC    = 1'b0;
        wbLoadC   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state)
            IDLE: begin
                // Only non-memory entries can sit in EX/MEM while idle
                wbLoadC = exValid;
                if (acceptMem) nextState = ACCESS;
            end
            ACCESS: begin
                mem_write = exMemWr;
                mem_read  = exMemRd && !exMemWr;
                mem_addr  = exAlu;
                mem_wdata = exStore;
                stallC    = !mem_ack;
                wbLoadC   = mem_ack;
                if (mem_ack) nextState = acceptMem ? ACCESS : IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // EX/MEM register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exValid <= 1'b0;
            exPc    <= '0;
            exAlu   <= '0;
            exStore <= '0;
            exRd    <= '0;
            exMemRd <= 1'b0;
            exMemWr <= 1'b0;
            exWbSrc <= 2'd0;
            exRegWr <= 1'b0;
        end else if (!stallC) begin
            exValid <= in_valid && !in_flush;
            exPc    <= in_pc;
            exAlu   <= in_alu_out;
            exStore <= in_store_data;
            exRd    <= in_rd;
            exMemRd <= in_mem_read;
            exMemWr <= in_mem_write;
            exWbSrc <= in_wb_src;
            exRegWr <= in_reg_write;
        end
    end

    mem_wb_mux #(
        .WIDTH(WIDTH)
    ) uWbMux (
        .wbSrc    (exWbSrc),
        .aluOut   (exAlu),
        .memData  (mem_rdata),
        .pc       (exPc),
        .selData_c(muxDataC)
    );

    // MEM/WB register; read data is captured through the mux on the ack edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wb_valid     <= 1'b0;
            wb_pc        <= '0;
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            wb_data      <= '0;
        end else begin
            wb_valid     <= wbLoadC;
            wb_pc        <= exPc;
            wb_rd        <= exRd;
            wb_reg_write <= wbLoadC && exRegWr;
            wb_data      <= muxDataC;
        end
    end

`ifdef MEM_STAGE_FWD_EN
    // Forward ALU and link results still held in EX/MEM
    always_comb begin
        fwd_valid = 1'b0;
        fwd_rd    = exRd;
        fwd_data  = '0;
        if (exValid && exRegWr && !exMemRd) begin
            if (exWbSrc == WB_ALU) begin
                fwd_valid = 1'b1;
                fwd_data  = exAlu;
            end else if (exWbSrc == WB_PC1) begin
                fwd_valid = 1'b1;
                fwd_data  = exPc + WIDTH'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_hs.sv
// Randomized self-checking bench for mem_stage_hs against a transaction-level model.
module tb_mem_stage_hs;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [15:0] in_pc;
    logic [15:0] in_alu_out;
    logic [15:0] in_store_data;
    logic [1:0]  in_rd;
    logic        in_mem_read;
    logic        in_mem_write;
    logic [1:0]  in_wb_src;
    logic        in_reg_write;
    logic        in_flush;
    logic        stall_out;
    logic        mem_read;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
`ifdef MEM_STAGE_FWD_EN
    logic        fwd_valid;
    logic [1:0]  fwd_rd;
    logic [15:0] fwd_data;
`endif
    logic        wb_valid;
    logic [15:0] wb_pc;
    logic [1:0]  wb_rd;
    logic        wb_reg_write;
    logic [15:0] wb_data;

    mem_stage_hs dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_alu_out   (in_alu_out),
        .in_store_data(in_store_data),
        .in_rd        (in_rd),
        .in_mem_read  (in_mem_read),
        .in_mem_write (in_mem_write),
        .in_wb_src    (in_wb_src),
        .in_reg_write (in_reg_write),
        .in_flush     (in_flush),
        .stall_out    (stall_out),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
`ifdef MEM_STAGE_FWD_EN
        .fwd_valid    (fwd_valid),
        .fwd_rd       (fwd_rd),
        .fwd_data     (fwd_data),
`endif
        .wb_valid     (wb_valid),
        .wb_pc        (wb_pc),
        .wb_rd        (wb_rd),
        .wb_reg_write (wb_reg_write),
        .wb_data      (wb_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] pc;
        logic [15:0] alu;
        logic [15:0] st;
        logic [1:0]  rd;
        logic [1:0]  src;
        logic        memRd;
        logic        memWr;
        logic        regWr;
        logic [15:0] rdata;
    } ent_t;

    int   checks = 0;
    int   failures = 0;

    // Model: the entry held in the stage, and what WB should show this cycle
    bit   mValid;
    ent_t mEnt;
    bit   expWbV;
    ent_t expWb;
    int   reqWait;
    int   curLat;

    int   ackLat = 0;
    bit   spurious = 0;
    bit   forceAck = 0;
    bit   useFixed = 1;
    logic [15:0] fixedRdata = 16'hBEEF;
    int   rdCycles;
    int   wrCycles;
    int   stallCycles;
    bit   acc;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] expData(input ent_t e);
        case (e.src)
            2'd0:    return e.alu;
            2'd1:    return e.rdata;
            2'd2:    return e.pc + 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    task automatic setIn(input logic v, input logic [15:0] pc, input logic [15:0] alu,
                         input logic [15:0] st, input logic [1:0] rd, input logic mr,
                         input logic mw, input logic [1:0] src, input logic rw, input logic fl);
        in_valid = v; in_pc = pc; in_alu_out = alu; in_store_data = st; in_rd = rd;
        in_mem_read = mr; in_mem_write = mw; in_wb_src = src; in_reg_write = rw; in_flush = fl;
    endtask

    task automatic randIn();
        int kind;
        kind = int'($urandom_range(0, 4));
        setIn(($urandom_range(0, 9) != 0), 16'($urandom), 16'($urandom), 16'($urandom),
              2'($urandom), (kind == 0 || kind == 2), (kind == 1 || kind == 2),
              2'($urandom), 1'($urandom), ($urandom_range(0, 9) == 0));
    endtask

    // One clock cycle: drive memory response, check outputs, advance model. Starts and ends at negedge.
    task automatic tick(output bit accepted);
        logic        memReq;
        logic        ack;
        logic [15:0] rdv;
        memReq = mValid && (mEnt.memRd || mEnt.memWr);
        rdv = useFixed ? fixedRdata : 16'($urandom);
        if (memReq) ack = (reqWait >= curLat);
        else        ack = forceAck || (spurious && ($urandom_range(0, 3) == 0));
        mem_ack = ack;
        mem_rdata = rdv;
        #1;
        checkEq("stall_out", 32'(stall_out), 32'(memReq && !ack));
        checkEq("mem_write", 32'(mem_write), 32'(memReq && mEnt.memWr));
        checkEq("mem_read", 32'(mem_read), 32'(memReq && mEnt.memRd && !mEnt.memWr));
        if (memReq) begin
            checkEq("mem_addr", 32'(mem_addr), 32'(mEnt.alu));
            checkEq("mem_wdata", 32'(mem_wdata), 32'(mEnt.st));
        end
        checkEq("wb_valid", 32'(wb_valid), 32'(expWbV));
        checkEq("wb_reg_write", 32'(wb_reg_write), 32'(expWbV && expWb.regWr));
        if (expWbV) begin
            checkEq("wb_pc", 32'(wb_pc), 32'(expWb.pc));
            checkEq("wb_rd", 32'(wb_rd), 32'(expWb.rd));
            checkEq("wb_data", 32'(wb_data), 32'(expData(expWb)));
        end
`ifdef MEM_STAGE_FWD_EN
        begin
            bit fv;
            fv = mValid && mEnt.regWr && !mEnt.memRd && (mEnt.src == 2'd0 || mEnt.src == 2'd2);
            checkEq("fwd_valid", 32'(fwd_valid), 32'(fv));
            if (fv) begin
                checkEq("fwd_rd", 32'(fwd_rd), 32'(mEnt.rd));
                checkEq("fwd_data", 32'(fwd_data),
                        32'((mEnt.src == 2'd0) ? mEnt.alu : mEnt.pc + 16'd1));
            end
        end
`endif
        if (mem_read) rdCycles++;
        if (mem_write) wrCycles++;
        if (stall_out) stallCycles++;
        accepted = !(memReq && !ack);
        @(posedge clk);
        expWbV = 0;
        if (mValid && (!memReq || ack)) begin
            expWb = mEnt;
            expWb.rdata = rdv;
            expWbV = 1;
            mValid = 0;
        end else if (memReq) begin
            reqWait++;
        end
        if (accepted) begin
            mValid = in_valid && !in_flush;
            if (mValid) begin
                mEnt.pc = in_pc; mEnt.alu = in_alu_out; mEnt.st = in_store_data;
                mEnt.rd = in_rd; mEnt.src = in_wb_src; mEnt.memRd = in_mem_read;
                mEnt.memWr = in_mem_write; mEnt.regWr = in_reg_write; mEnt.rdata = 16'd0;
            end
            reqWait = 0;
            curLat = (ackLat >= 0) ? ackLat : int'($urandom_range(0, 3));
        end
        @(negedge clk);
    endtask

    task automatic clearCounts();
        rdCycles = 0; wrCycles = 0; stallCycles = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        mem_ack = 1'b0;
        mem_rdata = 16'd0;
        setIn(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        mValid = 0; expWbV = 0; reqWait = 0; curLat = 0;
        clearCounts();
        @(negedge clk);
        @(negedge clk);
        checkEq("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkEq("rst_wb_data", 32'(wb_data), 32'd0);
        checkEq("rst_stall", 32'(stall_out), 32'd0);
        checkEq("rst_mem_rw", 32'({mem_read, mem_write}), 32'd0);
        checkEq("rst_mem_addr", 32'(mem_addr), 32'd0);
        reset_n = 1'b1;

        // ALU op written back one cycle after acceptance
        setIn(1, 16'h0100, 16'h1234, 16'h0, 2'd1, 0, 0, 2'd0, 1, 0);
        tick(acc);
`ifdef MEM_STAGE_FWD_EN
        checkEq("fwd_alu_valid", 32'(fwd_valid), 32'd1);
        checkEq("fwd_alu_data", 32'(fwd_data), 32'h1234);
`endif
        in_valid = 0;
        tick(acc);
        checkEq("alu_wb_valid", 32'(wb_valid), 32'd1);
        checkEq("alu_wb_data", 32'(wb_data), 32'h1234);
        checkEq("alu_wb_rd", 32'(wb_rd), 32'd1);
        checkEq("alu_no_mem", 32'({mem_read, mem_write}), 32'd0);

        // Link value wraps at full width
        setIn(1, 16'hFFFF, 16'h0F0F, 16'h0, 2'd3, 0, 0, 2'd2, 1, 0);
        tick(acc);
        in_valid = 0;
        tick(acc);
        checkEq("pc1_wrap", 32'(wb_data), 32'd0);

        // Load, ack on the third request cycle
        ackLat = 2;
        setIn(1, 16'h0200, 16'h0040, 16'h0, 2'd3, 1, 0, 2'd1, 1, 0);
        tick(acc);
        in_valid = 0;
        clearCounts();
        for (int i = 0; i < 3; i++) tick(acc);
        checkEq("ld_rd_cycles", 32'(rdCycles), 32'd3);
        checkEq("ld_stall_cycles", 32'(stallCycles), 32'd2);
        checkEq("ld_wb_valid", 32'(wb_valid), 32'd1);
        checkEq("ld_wb_data", 32'(wb_data), 32'hBEEF);

        // Store acked in its first cycle
        ackLat = 0;
        setIn(1, 16'h0300, 16'h0010, 16'hA5A5, 2'd2, 0, 1, 2'd0, 0, 0);
        clearCounts();
        tick(acc);
        in_valid = 0;
        tick(acc);
        checkEq("st_wr_cycles", 32'(wrCycles), 32'd1);
        checkEq("st_stall_cycles", 32'(stallCycles), 32'd0);
        checkEq("st_wb_valid", 32'(wb_valid), 32'd1);
        checkEq("st_wb_reg_write", 32'(wb_reg_write), 32'd0);

        // Back-to-back: ALU op presented in the load's ack cycle
        ackLat = 1;
        setIn(1, 16'h0400, 16'h0044, 16'h0, 2'd1, 1, 0, 2'd1, 1, 0);
        tick(acc);
        in_valid = 0;
        tick(acc);
        setIn(1, 16'h0500, 16'h5555, 16'h0, 2'd2, 0, 0, 2'd0, 1, 0);
        tick(acc);
        checkEq("b2b_accept", 32'(acc), 32'd1);
        in_valid = 0;
        checkEq("b2b_first_pc", 32'(wb_pc), 32'h0400);
        tick(acc);
        checkEq("b2b_second_pc", 32'(wb_pc), 32'h0500);
        checkEq("b2b_second_data", 32'(wb_data), 32'h5555);
        tick(acc);
        checkEq("b2b_no_dup", 32'(wb_valid), 32'd0);

`ifdef MEM_STAGE_FWD_EN
        ackLat = 0;
        setIn(1, 16'h0600, 16'h0007, 16'h0, 2'd2, 0, 0, 2'd0, 1, 0);
        tick(acc);
        checkEq("fwd_valid", 32'(fwd_valid), 32'd1);
        checkEq("fwd_rd", 32'(fwd_rd), 32'd2);
        checkEq("fwd_data", 32'(fwd_data), 32'h0007);
        setIn(1, 16'h0700, 16'h0070, 16'h0, 2'd2, 1, 0, 2'd1, 1, 0);
        tick(acc);
        checkEq("fwd_load", 32'(fwd_valid), 32'd0);
        in_valid = 0;
        tick(acc);
        tick(acc);
`endif

        // Reset pulse in the middle of an access, then a late ack
        ackLat = 5;
        setIn(1, 16'h0800, 16'h0080, 16'h0, 2'd0, 1, 0, 2'd1, 1, 0);
        tick(acc);
        in_valid = 0;
        tick(acc);
        reset_n = 1'b0;
        #1;
        checkEq("arst_mem_read", 32'(mem_read), 32'd0);
        checkEq("arst_stall", 32'(stall_out), 32'd0);
        checkEq("arst_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        mValid = 0; expWbV = 0;
        forceAck = 1;
        tick(acc);
        forceAck = 0;
        checkEq("late_ack_wb", 32'(wb_valid), 32'd0);
        checkEq("late_ack_req", 32'({mem_read, mem_write}), 32'd0);
        checkEq("late_ack_stall", 32'(stall_out), 32'd0);

        // Random traffic with random ack latency and stray acks while idle
        ackLat = -1;
        spurious = 1;
        useFixed = 0;
        acc = 1;
        for (int i = 0; i < 500; i++) begin
            if (acc) randIn();
            tick(acc);
        end
        in_valid = 0;
        for (int i = 0; i < 8; i++) tick(acc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
